// File: rtl/bram_channel_packer.sv
// bram_channel_packer
//   Read-side front end between the address controller and the per-channel
//   image BRAMs. Accepted addresses are forwarded straight to the BRAMs.
//   A valid/addr/last shift register tracks each read through the BRAM
//   latency. Out-of-frame reads are zero-masked. The channels are packed
//   into one word, and the words are buffered in a credit-controlled
//   first-word-fall-through FIFO.
//
// Optional feature macro: PACKER_OOB_FLAG_EN
//   Adds out_oob_o, which flags a masked head word, and oob_count_o, a
//   saturating count of masked words pushed.
//
// Ports
//   clk_i          single clock, shared with the BRAMs
//   reset_i        asynchronous, active-high
//   clear_i        synchronous flush of in-flight reads and FIFO
//   addr_in_i      read address; addr_last_i frame tag; addr_valid_i qualifier
//   addr_ready_o   address accepted this cycle when addr_valid_i is high
//   bram_en_o      shared BRAM enable (= accept)
//   bram_addr_o    shared BRAM address
//   bram_rdata_i   channel k on [k*CH_WIDTH +: CH_WIDTH]
//   out_data_o     packed word; channel 0 sits in the highest field
//   out_last_o     frame tag of out_data_o
//   out_valid_o    FIFO not empty
//   out_ready_i    consumer accepts the head word
//   busy_o         reads in flight or FIFO not empty
module bram_channel_packer #(
  parameter int          CH_NUM     = 3,
  parameter int          CH_WIDTH   = 16,
  parameter int          OUT_WIDTH  = 64,
  parameter int          ADDR_WIDTH = 13,
  parameter int unsigned MAX_ADDR   = 7056,
  parameter int          RD_LATENCY = 2,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clear_i,
  input  logic [ADDR_WIDTH-1:0]        addr_in_i,
  input  logic                         addr_last_i,
  input  logic                         addr_valid_i,
  output logic                         addr_ready_o,
  output logic                         bram_en_o,
  output logic [ADDR_WIDTH-1:0]        bram_addr_o,
  input  logic [CH_NUM*CH_WIDTH-1:0]   bram_rdata_i,
  output logic [OUT_WIDTH-1:0]         out_data_o,
  output logic                         out_last_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         busy_o
`ifdef PACKER_OOB_FLAG_EN
  ,
  output logic                         out_oob_o,
  output logic [15:0]                  oob_count_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  // Wide enough to hold inflight + occ without wrapping.
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
`ifdef PACKER_OOB_FLAG_EN
  localparam int ENTRY_W = OUT_WIDTH + 2;
`else
  localparam int ENTRY_W = OUT_WIDTH + 1;
`endif
  localparam logic [ADDR_WIDTH:0] MAX_ADDR_C = (ADDR_WIDTH + 1)'(MAX_ADDR);
  localparam logic [CNT_W-1:0]    DEPTH_C    = CNT_W'(FIFO_DEPTH);

  logic                  rdy_en_q;
  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [RD_LATENCY-1:0] pipe_last_q;
  logic [ADDR_WIDTH-1:0] pipe_addr_q [RD_LATENCY];
  logic [ENTRY_W-1:0]    fifo_mem_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [OCC_W-1:0]      occ_q;
`ifdef PACKER_OOB_FLAG_EN
  logic [15:0]           oob_cnt_q;
`endif

  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      credit_used;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  masked;
  logic [OUT_WIDTH-1:0]  packed_word;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_vld_q[i]);
    end
  end

  // Every accepted address has a reserved FIFO slot, counted from the
  // moment it enters the pipeline. Pushes therefore never need to stall.
  assign credit_used  = inflight + CNT_W'(occ_q);
  // rdy_en_q keeps ready low until the first edge after reset release.
  assign addr_ready_o = rdy_en_q & ~clear_i & (credit_used < DEPTH_C);
  assign accept       = addr_valid_i & addr_ready_o;
  assign bram_en_o    = accept;
  assign bram_addr_o  = accept ? addr_in_i : '0;

  assign masked = ({1'b0, pipe_addr_q[RD_LATENCY-1]} >= MAX_ADDR_C);
  assign push   = pipe_vld_q[RD_LATENCY-1] & ~clear_i;

  assign out_valid_o = (occ_q != '0);
  assign pop         = out_valid_o & out_ready_i & ~clear_i;
  assign busy_o      = (inflight != '0) | out_valid_o;

  always_comb begin
    packed_word = '0;
    if (!masked) begin
      for (int k = 0; k < CH_NUM; k++) begin
        packed_word[(CH_NUM-k)*CH_WIDTH-1 -: CH_WIDTH] = bram_rdata_i[k*CH_WIDTH +: CH_WIDTH];
      end
    end
  end

`ifdef PACKER_OOB_FLAG_EN
  assign push_entry = {masked, pipe_last_q[RD_LATENCY-1], packed_word};
`else
  assign push_entry = {pipe_last_q[RD_LATENCY-1], packed_word};
`endif

  // Gating the head with out_valid gives zero outputs while empty. It also
  // makes the outputs follow an asynchronous reset immediately.
  assign head_entry = out_valid_o ? fifo_mem_q[rd_ptr_q] : '0;
  assign out_data_o = head_entry[OUT_WIDTH-1:0];
  assign out_last_o = head_entry[OUT_WIDTH];
`ifdef PACKER_OOB_FLAG_EN
  assign out_oob_o   = head_entry[OUT_WIDTH+1];
  assign oob_count_o = oob_cnt_q;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rdy_en_q    <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
`ifdef PACKER_OOB_FLAG_EN
      oob_cnt_q   <= '0;
`endif
    end else begin
      rdy_en_q <= 1'b1;
      if (clear_i) begin
        pipe_vld_q  <= '0;
        pipe_last_q <= '0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        occ_q       <= '0;
`ifdef PACKER_OOB_FLAG_EN
        oob_cnt_q   <= '0;
`endif
      end else begin
        pipe_vld_q[0]  <= accept;
        pipe_last_q[0] <= addr_last_i;
        for (int i = 1; i < RD_LATENCY; i++) begin
          pipe_vld_q[i]  <= pipe_vld_q[i-1];
          pipe_last_q[i] <= pipe_last_q[i-1];
        end
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   occ_q <= occ_q + 1'b1;
          2'b01:   occ_q <= occ_q - 1'b1;
          default: occ_q <= occ_q;
        endcase
`ifdef PACKER_OOB_FLAG_EN
        if (push && masked && (oob_cnt_q != 16'hFFFF)) oob_cnt_q <= oob_cnt_q + 1'b1;
`endif
      end
    end
  end

  // Data-path storage needs no reset; validity is tracked by the pipeline
  // valids and by the FIFO occupancy.
  always_ff @(posedge clk_i) begin
    pipe_addr_q[0] <= addr_in_i;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_addr_q[i] <= pipe_addr_q[i-1];
    end
    if (push) fifo_mem_q[wr_ptr_q] <= push_entry;
  end

endmodule
